// File: rtl/simm_march_if.sv
// rtl/simm_march_if.sv - request/data port between the march tester and the SIMM DRAM controller
interface simm_march_if;
  logic [23:0] mem_addr;
  logic        mem_write;
  logic        mem_ena;
  logic [7:0]  mem_wdata;
  logic        mem_wdata_oe;
  logic [7:0]  mem_rdata;
  logic        mem_busy;
  logic        mem_ack;

  modport master (
    output mem_addr, mem_write, mem_ena, mem_wdata, mem_wdata_oe,
    input  mem_rdata, mem_busy, mem_ack
  );

  modport slave (
    input  mem_addr, mem_write, mem_ena, mem_wdata, mem_wdata_oe,
    output mem_rdata, mem_busy, mem_ack
  );
endinterface

// File: rtl/simm_march_test.sv
// rtl/simm_march_test.sv - four-pass write/verify march tester for the 16 MB SIMM DRAM controller
// Optional SIMM_TEST_STOP_ON_ERR_EN: stop at the first mismatch instead of counting all of them.
module simm_march_test #(
  parameter logic [23:0] LAST_ADDR = 24'hFFFFFF,
  parameter logic [7:0]  SEED      = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  output logic        pass,
  output logic [1:0]  phase,
  output logic [15:0] err_count,
  output logic [23:0] fail_addr,
  output logic [7:0]  fail_data,
  simm_march_if.master mem
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [23:0] addr_q, addr_d;
  logic [1:0]  phase_q, phase_d;
  logic [15:0] err_q, err_d;
  logic [23:0] fail_addr_q, fail_addr_d;
  logic [7:0]  fail_data_q, fail_data_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        done_q, done_d;

  logic [7:0] pattern;
  logic [7:0] expected;
  logic       is_write;
  logic       active;
  logic       mismatch;

  assign pattern  = addr_q[7:0] ^ addr_q[15:8] ^ addr_q[23:16] ^ SEED;
  assign expected = phase_q[1] ? ~pattern : pattern;
  assign is_write = ~phase_q[0];
  // Address, direction and data stay on the bus through WAIT: the controller samples row/column late.
  assign active   = (state_q == S_REQ) || (state_q == S_WAIT);
  assign mismatch = phase_q[0] && (rdata_q != expected);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    err_d       = err_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    rdata_d     = rdata_q;
    done_d      = done_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = 24'd0;
          phase_d     = 2'd0;
          err_d       = 16'd0;
          fail_addr_d = 24'd0;
          fail_data_d = 8'd0;
          done_d      = 1'b0;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        // An ack without busy is a leftover from the previous cycle, not an acceptance.
        if (mem.mem_ack && mem.mem_busy) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!mem.mem_busy) begin
          rdata_d = mem.mem_rdata;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = S_REQ;
        if (mismatch) begin
          if (err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
          end
          if (err_q == 16'd0) begin
            fail_addr_d = addr_q;
            fail_data_d = rdata_q;
          end
        end
`ifdef SIMM_TEST_STOP_ON_ERR_EN
        if (mismatch) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else
`endif
        if (addr_q == LAST_ADDR) begin
          addr_d = 24'd0;
          if (phase_q == 2'd3) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            phase_d = phase_q + 2'd1;
          end
        end else begin
          addr_d = addr_q + 24'd1;
        end
      end
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= 24'd0;
      phase_q     <= 2'd0;
      err_q       <= 16'd0;
      fail_addr_q <= 24'd0;
      fail_data_q <= 8'd0;
      rdata_q     <= 8'd0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
    end
  end

  assign mem.mem_ena      = (state_q == S_REQ);
  assign mem.mem_addr     = addr_q;
  assign mem.mem_write    = active && is_write;
  assign mem.mem_wdata    = active ? expected : 8'd0;
  assign mem.mem_wdata_oe = active && is_write;

  assign done      = done_q;
  assign pass      = done_q && (err_q == 16'd0);
  assign phase     = phase_q;
  assign err_count = err_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;

endmodule
